// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial full subtractor, diff = a - b - bin over WIDTH
//                bits, one bit per clock LSB first, with start/busy/done
//                handshake and borrow-out, signed-overflow and zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_a0;
    logic               w_b0;
    logic               w_d;
    logic               w_br_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    // Per-bit full-subtractor cell and the partial result after this bit
    assign w_a0      = r_a_sh[0];
    assign w_b0      = r_b_sh[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_br;
    assign w_br_nxt  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_res_nxt = {w_d, r_res_sh[WIDTH-1:1]};
    assign w_last    = (r_cnt == C_LAST_BIT);

    // start is only honoured when no operation is in flight
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Status outputs decode the state register only, so they stay glitch-free
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE lasts one cycle and may chain straight into RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, serial datapath, and result load on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_br   <= bin;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_res_nxt;
            r_br     <= w_br_nxt;
            if (w_last) begin
                r_cnt <= '0;
                diff  <= w_res_nxt;
                bout  <= w_br_nxt;
                // r_br still holds the borrow into the MSB on this edge
                ovf   <= r_br ^ w_br_nxt;
                zero  <= (w_res_nxt == '0);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor at WIDTH 8, 2, 16,
//                directed cases plus random operands against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        bin_in;

    logic        busy8, done8, bout8, ovf8, zero8;
    logic [7:0]  diff8;
    logic        busy2, done2, bout2, ovf2, zero2;
    logic [1:0]  diff2;
    logic        busy16, done16, bout16, ovf16, zero16;
    logic [15:0] diff16;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
        .busy(busy8), .done(done8), .diff(diff8),
        .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_in[1:0]), .b(b_in[1:0]), .bin(bin_in),
        .busy(busy2), .done(done2), .diff(diff2),
        .bout(bout2), .ovf(ovf2), .zero(zero2)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy16), .done(done16), .diff(diff16),
        .bout(bout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int width_of(input int idx);
        case (idx)
            0:       return 8;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    task automatic sample(input int idx, output logic [15:0] d, output logic bs,
                          output logic dn, output logic bo, output logic ov, output logic z);
        case (idx)
            0: begin d = {8'h00, diff8};  bs = busy8;  dn = done8;  bo = bout8;  ov = ovf8;  z = zero8;  end
            1: begin d = {14'h0, diff2};  bs = busy2;  dn = done2;  bo = bout2;  ov = ovf2;  z = zero2;  end
            default: begin d = diff16;    bs = busy16; dn = done16; bo = bout16; ov = ovf16; z = zero16; end
        endcase
    endtask

    // Reference: plain integer arithmetic on unsigned and signed readings of the operands
    task automatic ref_model(input int w, input longint a, input longint b, input longint bin,
                             output logic [15:0] d, output logic bo, output logic ov, output logic z);
        longint m  = longint'(1) << w;
        longint r  = a - b - bin;
        longint sa = (a >= m / 2) ? a - m : a;
        longint sb = (b >= m / 2) ? b - m : b;
        longint sr = sa - sb - bin;
        d  = 16'(r & (m - 1));
        bo = (a < b + bin);
        ov = (sr < -(m / 2)) || (sr > (m / 2 - 1));
        z  = (d == 16'h0);
    endtask

    // One full operation with latency checks; inject pulses start with junk operands mid-RUN
    task automatic run_op(input int idx, input logic [15:0] a_raw, input logic [15:0] b_raw,
                          input logic bi, input bit inject);
        int          w    = width_of(idx);
        logic [15:0] mask = 16'((32'd1 << w) - 1);
        logic [15:0] a    = a_raw & mask;
        logic [15:0] b    = b_raw & mask;
        logic [15:0] ed, d;
        logic        eb, eo, ez, bs, dn, bo, ov, z;
        ref_model(w, longint'(a), longint'(b), longint'(bi), ed, eb, eo, ez);
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bi; start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        for (int i = 1; i < w; i++) begin
            @(negedge clk);
            if (inject && i == 3) begin
                a_in = ~a; b_in = a; bin_in = ~bi; start_v[idx] = 1'b1;
            end else begin
                start_v[idx] = 1'b0;
            end
            sample(idx, d, bs, dn, bo, ov, z);
            check_eq("busy_run", bs, 1'b1);
            check_eq("done_early", dn, 1'b0);
        end
        @(negedge clk);
        start_v[idx] = 1'b0;
        sample(idx, d, bs, dn, bo, ov, z);
        check_eq("done_pulse", dn, 1'b1);
        check_eq("busy_at_done", bs, 1'b0);
        check_eq("diff", d, ed);
        check_eq("bout", bo, eb);
        check_eq("ovf", ov, eo);
        check_eq("zero", z, ez);
        @(negedge clk);
        sample(idx, d, bs, dn, bo, ov, z);
        check_eq("done_one_cycle", dn, 1'b0);
        check_eq("diff_hold", d, ed);
    endtask

    initial begin : main
        logic [15:0] d, ed1, ed2;
        logic        bs, dn, bo, ov, z, eb1, eo1, ez1, eb2, eo2, ez2;
        int          gap;

        rst_n = 1'b0; start_v = '0; a_in = '0; b_in = '0; bin_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sample(k, d, bs, dn, bo, ov, z);
            check_eq("rst_busy", bs, 1'b0);
            check_eq("rst_done", dn, 1'b0);
            check_eq("rst_diff", d, 16'h0);
            check_eq("rst_bout", bo, 1'b0);
            check_eq("rst_ovf", ov, 1'b0);
            check_eq("rst_zero", z, 1'b0);
        end
        rst_n = 1'b1;

        // Directed cases at WIDTH=8
        run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0);
        check_eq("basic_diff_const", {8'h0, diff8}, 16'h1E);
        run_op(0, 16'h00, 16'h01, 1'b0, 1'b0);
        run_op(0, 16'h80, 16'h01, 1'b0, 1'b0);
        check_eq("ovf_const", ovf8, 1'b1);
        run_op(0, 16'h10, 16'h0F, 1'b1, 1'b0);
        check_eq("zero_const", zero8, 1'b1);
        run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b1);

        // Back-to-back: start held through DONE
        ref_model(8, 64'hC3, 64'h4D, 64'd0, ed1, eb1, eo1, ez1);
        ref_model(8, 64'h12, 64'h34, 64'd1, ed2, eb2, eo2, ez2);
        @(negedge clk);
        a_in = 16'hC3; b_in = 16'h4D; bin_in = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        a_in = 16'h12; b_in = 16'h34; bin_in = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        sample(0, d, bs, dn, bo, ov, z);
        check_eq("b2b_done1", dn, 1'b1);
        check_eq("b2b_diff1", d, ed1);
        check_eq("b2b_bout1", bo, eb1);
        @(negedge clk);
        start_v[0] = 1'b0;
        sample(0, d, bs, dn, bo, ov, z);
        check_eq("b2b_busy2", bs, 1'b1);
        check_eq("b2b_no_idle", dn, 1'b0);
        gap = 1;
        while (gap < 40) begin
            @(negedge clk);
            gap++;
            sample(0, d, bs, dn, bo, ov, z);
            if (dn) break;
        end
        check_eq("b2b_gap", gap, 9);
        check_eq("b2b_diff2", d, ed2);
        check_eq("b2b_bout2", bo, eb2);
        check_eq("b2b_ovf2", ov, eo2);
        check_eq("b2b_zero2", z, ez2);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        run_op(0, 16'h00, 16'h01, 1'b0, 1'b0);
        @(negedge clk);
        a_in = 16'h5A; b_in = 16'h3C; bin_in = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sample(0, d, bs, dn, bo, ov, z);
        check_eq("arst_busy", bs, 1'b0);
        check_eq("arst_done", dn, 1'b0);
        check_eq("arst_diff", d, 16'h0);
        check_eq("arst_bout", bo, 1'b0);
        check_eq("arst_ovf", ov, 1'b0);
        check_eq("arst_zero", z, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample(0, d, bs, dn, bo, ov, z);
            check_eq("no_done_after_rst", dn, 1'b0);
            check_eq("idle_after_rst", bs, 1'b0);
        end
        run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0);

        // Random sweep across all three widths
        for (int n = 0; n < 200; n++)
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        for (int n = 0; n < 1000; n++)
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        for (int n = 0; n < 1000; n++)
            run_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
